// File: rtl/keypad_pkg.sv
// Shared constants for the 4x4 keypad scanner: FSM state encodings,
// one-hot column drive values, key-code width and small bit helpers.
package keypad_pkg;

  localparam int unsigned KEY_W = 4;

  localparam logic [1:0] ST_SCAN    = 2'd0;
  localparam logic [1:0] ST_CONFIRM = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [3:0] COL_0 = 4'b0001;
  localparam logic [3:0] COL_1 = 4'b0010;
  localparam logic [3:0] COL_2 = 4'b0100;
  localparam logic [3:0] COL_3 = 4'b1000;

  // Index of the lowest set bit; used both for the row that wins a
  // multi-row press and for turning the one-hot column into an index.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    if (v[0])      idx = 2'd0;
    else if (v[1]) idx = 2'd1;
    else if (v[2]) idx = 2'd2;
    else           idx = 2'd3;
    return idx;
  endfunction

  function automatic logic [3:0] col_next(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

endpackage

// File: rtl/scan_tick.sv
// Slot timer for the keypad scanner.
//   clk  : clock
//   rst  : synchronous active-low reset
//   tick : high on the last cycle of every SCAN_DIV-cycle slot
module scan_tick #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst)      cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with press/release debouncing.
//   clk      : clock
//   rst      : synchronous active-low reset
//   fila     : row inputs (asynchronous, high = key pressed in driven column)
//   col      : one-hot column drive
//   posicion : last confirmed key code (row*4 + column)
//   opr      : one-cycle strobe when posicion is updated
//   held     : high while a confirmed key is still pressed
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEB_N    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       fila,
  output logic [3:0]       col,
  output logic [KEY_W-1:0] posicion,
  output logic             opr,
  output logic             held
);

  localparam logic [7:0] LAST = 8'(DEB_N - 1);

  logic             tick;
  logic [3:0]       fs_meta;
  logic [3:0]       fs;
  logic [1:0]       state;
  logic [3:0]       row_pat;
  logic [KEY_W-1:0] key_code;
  logic [7:0]       match_cnt;

  scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      fs_meta   <= '0;
      fs        <= '0;
      state     <= ST_SCAN;
      col       <= COL_0;
      row_pat   <= '0;
      key_code  <= '0;
      match_cnt <= '0;
      posicion  <= '0;
      opr       <= 1'b0;
      held      <= 1'b0;
    end else begin
      fs_meta <= fila;
      fs      <= fs_meta;
      opr     <= 1'b0;
      if (tick) begin
        case (state)
          ST_SCAN: begin
            if (fs == '0) begin
              col <= col_next(col);
            end else begin
              // Whole row pattern is kept so any change during debounce aborts.
              row_pat   <= fs;
              key_code  <= {low_index(fs), low_index(col)};
              match_cnt <= 8'd1;
              state     <= ST_CONFIRM;
            end
          end
          ST_CONFIRM: begin
            if (fs == row_pat) begin
              if (match_cnt == LAST) begin
                posicion <= key_code;
                opr      <= 1'b1;
                held     <= 1'b1;
                state    <= ST_HOLD;
              end else begin
                match_cnt <= match_cnt + 8'd1;
              end
            end else begin
              col   <= col_next(col);
              state <= ST_SCAN;
            end
          end
          ST_HOLD: begin
            if (fs == '0) begin
              match_cnt <= 8'd1;
              state     <= ST_RELEASE;
            end
          end
          ST_RELEASE: begin
            // held stays high until the release is confirmed.
            if (fs != '0) begin
              state <= ST_HOLD;
            end else if (match_cnt == LAST) begin
              col   <= col_next(col);
              held  <= 1'b0;
              state <= ST_SCAN;
            end else begin
              match_cnt <= match_cnt + 8'd1;
            end
          end
          default: state <= ST_SCAN;
        endcase
      end
    end
  end

endmodule
